regs_cmd_master: RTL and testbench

- Initiator (bus-master) end of the register-file access interface: the side that drives addr / write_en / read_en / write_data and consumes read_data.
- Takes a byte stream from the UART receive path and parses binary command frames.
- Issues single register reads and writes, then returns a one-byte response on the UART transmit stream.
- Sits between the UART RX/TX byte handshakes and the register file slave port.

---
 rtl/regs_cmd_master_if.sv | 33 +++
 rtl/regs_cmd_master.sv | 204 ++++++++++++++++++++
 tb/tb_regs_cmd_master.sv | 351 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/regs_cmd_master_if.sv
// Register-command link bundle: UART RX byte stream, UART TX byte stream and
// the register-file access bus. The master modport is the command parser's view;
// the slave modport is the view of whatever sits on the far side (UART + regfile).
interface regs_cmd_master_if #(
  parameter int AW = 6
);
  // UART receive stream (into the parser)
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          rx_ready;
  // UART transmit stream (out of the parser)
  logic [7:0]    tx_data;
  logic          tx_valid;
  logic          tx_ready;
  // Register-file access bus
  logic [AW-1:0] reg_addr;
  logic          reg_write_en;
  logic [7:0]    reg_write_data;
  logic          reg_read_en;
  logic [7:0]    reg_read_data;

  modport master (
    input  rx_data, rx_valid, tx_ready, reg_read_data,
    output rx_ready, tx_data, tx_valid,
    output reg_addr, reg_write_en, reg_write_data, reg_read_en
  );

  modport slave (
    output rx_data, rx_valid, tx_ready, reg_read_data,
    input  rx_ready, tx_data, tx_valid,
    input  reg_addr, reg_write_en, reg_write_data, reg_read_en
  );
endinterface

// File: rtl/regs_cmd_master.sv
// Binary command parser that turns UART byte frames into single register-file
// reads/writes and answers each frame with exactly one response byte.
//   'W' addr data -> write, answer 'K'
//   'R' addr      -> read,  answer the read data
//   anything bad  -> answer 'E'
// Optional feature macro: REGS_CMD_WRITE_VERIFY_EN (read back every write and
// answer 'E' when the register did not take the value).
module regs_cmd_master #(
  parameter int DATA_DEPTH     = 64,
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic               clk,
  input  logic               rst,
  regs_cmd_master_if.master  bus,
  output logic               busy
);

  localparam int AW = $clog2(DATA_DEPTH);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [7:0] OP_WRITE = 8'h57;  // 'W'
  localparam logic [7:0] OP_READ  = 8'h52;  // 'R'
  localparam logic [7:0] RSP_OK   = 8'h4B;  // 'K'
  localparam logic [7:0] RSP_ERR  = 8'h45;  // 'E'

  if (DATA_WIDTH != 8) begin : g_bad_width
    $error("regs_cmd_master: only DATA_WIDTH = 8 is supported");
  end
  if (DATA_DEPTH > 256 || DATA_DEPTH < 2) begin : g_bad_depth
    $error("regs_cmd_master: DATA_DEPTH must be 2..256 (8-bit address byte)");
  end

  typedef enum logic [3:0] {
    S_IDLE,
    S_GET_ADDR,
    S_GET_DATA,
    S_BUS_WR,
    S_BUS_RD,
    S_RD_CAP,
    S_RESP
`ifdef REGS_CMD_WRITE_VERIFY_EN
    , S_VF_RD,
    S_VF_CAP
`endif
  } state_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   tmo_q,   tmo_d;    // idle cycles since last accepted byte
  logic            is_wr_q, is_wr_d;  // latched opcode: 1 = write, 0 = read
  logic [AW-1:0]   addr_q,  addr_d;
  logic [7:0]      data_q,  data_d;
  logic [7:0]      resp_q,  resp_d;

  logic            rx_ready_c;
  logic            write_en_c;
  logic            read_en_c;
  logic            tx_valid_c;
  logic            tmo_hit;

  assign tmo_hit = (tmo_q == TW'(TIMEOUT_CYCLES));

  // State register and datapath latches; reset drops any frame in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      tmo_q   <= '0;
      is_wr_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      resp_q  <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values, independent of statement order.
      state_q <= state_d;
      tmo_q   <= tmo_d;
      is_wr_q <= is_wr_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      resp_q  <= resp_d;
    end
  end

  // Next-state, datapath updates and per-state handshake/strobe decode.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d    = state_q;
    tmo_d      = tmo_q;
    is_wr_d    = is_wr_q;
    addr_d     = addr_q;
    data_d     = data_q;
    resp_d     = resp_q;
    rx_ready_c = 1'b0;
    write_en_c = 1'b0;
    read_en_c  = 1'b0;
    tx_valid_c = 1'b0;

    case (state_q)
      S_IDLE: begin
        rx_ready_c = 1'b1;
        tmo_d      = '0;
        if (bus.rx_valid) begin
          if (bus.rx_data == OP_WRITE || bus.rx_data == OP_READ) begin
            is_wr_d = (bus.rx_data == OP_WRITE);
            state_d = S_GET_ADDR;
          end else begin
            resp_d  = RSP_ERR;
            state_d = S_RESP;
          end
        end
      end

      S_GET_ADDR: begin
        rx_ready_c = 1'b1;
        if (bus.rx_valid) begin
          tmo_d = '0;
          // Full 8-bit compare: an address like 0x45 must not alias onto 0x05.
          if (int'(bus.rx_data) >= DATA_DEPTH) begin
            resp_d  = RSP_ERR;
            state_d = S_RESP;
          end else begin
            addr_d  = bus.rx_data[AW-1:0];
            state_d = is_wr_q ? S_GET_DATA : S_BUS_RD;
          end
        end else if (tmo_hit) begin
          resp_d  = RSP_ERR;
          state_d = S_RESP;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end

      S_GET_DATA: begin
        rx_ready_c = 1'b1;
        if (bus.rx_valid) begin
          tmo_d   = '0;
          data_d  = bus.rx_data;
          state_d = S_BUS_WR;
        end else if (tmo_hit) begin
          resp_d  = RSP_ERR;
          state_d = S_RESP;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end

      S_BUS_WR: begin
        write_en_c = 1'b1;
`ifdef REGS_CMD_WRITE_VERIFY_EN
        state_d    = S_VF_RD;
`else
        resp_d     = RSP_OK;
        state_d    = S_RESP;
`endif
      end

      S_BUS_RD: begin
        read_en_c = 1'b1;
        state_d   = S_RD_CAP;
      end

      S_RD_CAP: begin
        resp_d  = bus.reg_read_data;
        state_d = S_RESP;
      end

`ifdef REGS_CMD_WRITE_VERIFY_EN
      S_VF_RD: begin
        read_en_c = 1'b1;
        state_d   = S_VF_CAP;
      end

      S_VF_CAP: begin
        resp_d  = (bus.reg_read_data == data_q) ? RSP_OK : RSP_ERR;
        state_d = S_RESP;
      end
`endif

      S_RESP: begin
        tx_valid_c = 1'b1;
        if (bus.tx_ready) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Reset holds the FSM in IDLE, where rx_ready would otherwise be 1; masking
  // with rst keeps the UART from handing over a byte that would be lost.
  assign bus.rx_ready       = rx_ready_c & ~rst;
  assign bus.tx_valid       = tx_valid_c;
  assign bus.tx_data        = resp_q;
  assign bus.reg_addr       = addr_q;
  assign bus.reg_write_data = data_q;
  assign bus.reg_write_en   = write_en_c;
  assign bus.reg_read_en    = read_en_c;
  assign busy               = (state_q != S_IDLE);

endmodule

// File: tb/tb_regs_cmd_master.sv
// Self-checking bench for regs_cmd_master: directed vector table, multi-cycle
// corner sequences (latency, timeout, back-pressure, reset) and a randomized
// phase scored against a frame-level reference model of the register file.
module tb_regs_cmd_master;

  localparam int DEPTH = 64;
  localparam int AW    = 6;
  localparam int TMO   = 40;
`ifdef REGS_CMD_WRITE_VERIFY_EN
  localparam int VF = 1;
`else
  localparam int VF = 0;
`endif

  localparam logic [7:0] W_OP = 8'h57;
  localparam logic [7:0] R_OP = 8'h52;
  localparam logic [7:0] K_RS = 8'h4B;
  localparam logic [7:0] E_RS = 8'h45;
  localparam logic [AW-1:0] RO_ADDR = 6'h3E;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy;

  regs_cmd_master_if #(.AW(AW)) bus ();

  regs_cmd_master #(
    .DATA_DEPTH    (DEPTH),
    .DATA_WIDTH    (8),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- register-file slave (one read-only register) ----------
  logic [7:0] slave_mem [DEPTH];
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) slave_mem[i] <= 8'h00;
      slave_mem[16]        <= 8'h3C;
      slave_mem[RO_ADDR]   <= 8'h99;
      bus.reg_read_data    <= 8'h00;
    end else begin
      if (bus.reg_write_en && bus.reg_addr != RO_ADDR)
        slave_mem[bus.reg_addr] <= bus.reg_write_data;
      if (bus.reg_read_en)
        bus.reg_read_data <= slave_mem[bus.reg_addr];
    end
  end

  // ---------------- cycle counter and strobe monitor ----------------------
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int wr_cnt = 0, rd_cnt = 0, wr_cyc = 0, rd_cyc = 0;
  logic [AW-1:0] last_wa, last_ra;
  logic [7:0]    last_wd;
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.reg_write_en) begin
        wr_cnt  <= wr_cnt + 1;
        wr_cyc  <= cyc;
        last_wa <= bus.reg_addr;
        last_wd <= bus.reg_write_data;
      end
      if (bus.reg_read_en) begin
        rd_cnt  <= rd_cnt + 1;
        rd_cyc  <= cyc;
        last_ra <= bus.reg_addr;
      end
    end
  end

  // ---------------- reference model ---------------------------------------
  logic [7:0] ref_mem [DEPTH];

  function automatic void ref_reset();
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 8'h00;
    ref_mem[16]      = 8'h3C;
    ref_mem[RO_ADDR] = 8'h99;
  endfunction

  // Frame-level semantics: how many bytes the frame consumes, the response
  // byte and how many strobes of each kind it must cause.
  function automatic void model_frame(input logic [7:0] op, input logic [7:0] a,
                                      input logic [7:0] d, output int n,
                                      output logic [7:0] resp, output int wr,
                                      output int rd);
    wr = 0; rd = 0;
    if (op != W_OP && op != R_OP) begin
      n = 1; resp = E_RS;
    end else if (int'(a) >= DEPTH) begin
      n = 2; resp = E_RS;
    end else if (op == R_OP) begin
      n = 2; resp = ref_mem[a[AW-1:0]]; rd = 1;
    end else begin
      n = 3; wr = 1; rd = VF;
      if (a[AW-1:0] != RO_ADDR) ref_mem[a[AW-1:0]] = d;
      resp = (VF == 1 && ref_mem[a[AW-1:0]] != d) ? E_RS : K_RS;
    end
  endfunction

  // ---------------- helpers ----------------------------------------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  int acc_cyc = 0;  // cycle stamp of the most recent accepted rx byte
  int tx_cyc  = 0;  // cycle stamp of the first tx_valid of the latest response

  task automatic idle_cycles(input int k);
    repeat (k) begin @(posedge clk); #1; end
  endtask

  // Present one byte; it transfers on the first edge where rx_ready is high.
  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    while (!bus.rx_ready && n < 200) begin @(posedge clk); #1; n++; end
    if (!bus.rx_ready) check("rx_ready wait", 32'd0, 32'd1);
    @(posedge clk); #1;
    acc_cyc      = cyc;
    bus.rx_valid = 1'b0;
  endtask

  // Wait for a response, optionally stall txd cycles, then hand it off.
  task automatic get_resp(input int txd, output logic [7:0] r);
    int  n;
    bit  stable;
    n = 0;
    while (!bus.tx_valid && n < 400) begin @(posedge clk); #1; n++; end
    if (!bus.tx_valid) check("tx_valid wait", 32'd0, 32'd1);
    tx_cyc = cyc;
    r      = bus.tx_data;
    stable = 1'b1;
    repeat (txd) begin
      @(posedge clk); #1;
      if (!bus.tx_valid || bus.tx_data !== r || bus.rx_ready) stable = 1'b0;
    end
    if (txd > 0) check("tx hold stable", 32'(stable), 32'd1);
    bus.tx_ready = 1'b1;
    @(posedge clk); #1;
    bus.tx_ready = 1'b0;
  endtask

  task automatic do_frame(input string name, input logic [7:0] b0, input logic [7:0] b1,
                          input logic [7:0] b2, input int n, input int gap, input int txd,
                          input logic [7:0] exp_resp, input int exp_wr, input int exp_rd);
    int wr0, rd0;
    logic [7:0] r;
    wr0 = wr_cnt;
    rd0 = rd_cnt;
    send_byte(b0);
    if (n > 1) begin idle_cycles(gap); send_byte(b1); end
    if (n > 2) begin idle_cycles(gap); send_byte(b2); end
    get_resp(txd, r);
    check({name, " resp"},   32'(r),          32'(exp_resp));
    check({name, " writes"}, 32'(wr_cnt - wr0), 32'(exp_wr));
    check({name, " reads"},  32'(rd_cnt - rd0), 32'(exp_rd));
    check({name, " busy"},   32'(busy),       32'd0);
  endtask

  typedef struct {
    logic [7:0] b0, b1, b2;
    int         n;
    logic [7:0] resp;
    int         wr, rd;
  } vec_t;

  vec_t vecs [13];

  // ---------------- test sequence -----------------------------------------
  initial begin
    logic [7:0] r, cap, op, a, d, er;
    int         en, ewr, erd, wr0, rd0, kind;
    bit         bad;

    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    bus.tx_ready = 1'b0;

    vecs[0]  = '{W_OP,  8'h05, 8'hA5, 3, K_RS,  1, VF};
    vecs[1]  = '{R_OP,  8'h05, 8'h00, 2, 8'hA5, 0, 1};
    vecs[2]  = '{R_OP,  8'h10, 8'h00, 2, 8'h3C, 0, 1};
    vecs[3]  = '{W_OP,  8'h40, 8'h00, 2, E_RS,  0, 0};
    vecs[4]  = '{8'h58, 8'h00, 8'h00, 1, E_RS,  0, 0};
    vecs[5]  = '{R_OP,  8'h80, 8'h00, 2, E_RS,  0, 0};
    vecs[6]  = '{R_OP,  8'hFF, 8'h00, 2, E_RS,  0, 0};
    vecs[7]  = '{W_OP,  8'h3F, 8'h5A, 3, K_RS,  1, VF};
    vecs[8]  = '{R_OP,  8'h3F, 8'h00, 2, 8'h5A, 0, 1};
    vecs[9]  = '{W_OP,  8'h00, 8'hC3, 3, K_RS,  1, VF};
    vecs[10] = '{R_OP,  8'h00, 8'h00, 2, 8'hC3, 0, 1};
    vecs[11] = '{R_OP,  8'h45, 8'h00, 2, E_RS,  0, 0};
    vecs[12] = '{8'h00, 8'h00, 8'h00, 1, E_RS,  0, 0};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst rx_ready",   32'(bus.rx_ready),       32'd0);
    check("rst tx_valid",   32'(bus.tx_valid),       32'd0);
    check("rst tx_data",    32'(bus.tx_data),        32'd0);
    check("rst busy",       32'(busy),               32'd0);
    check("rst write_en",   32'(bus.reg_write_en),   32'd0);
    check("rst read_en",    32'(bus.reg_read_en),    32'd0);
    check("rst reg_addr",   32'(bus.reg_addr),       32'd0);
    check("rst write_data", 32'(bus.reg_write_data), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("idle rx_ready", 32'(bus.rx_ready), 32'd1);

    // Directed vector table
    for (int i = 0; i < 13; i++) begin
      do_frame($sformatf("vec%0d", i), vecs[i].b0, vecs[i].b1, vecs[i].b2,
               vecs[i].n, i % 3, 0, vecs[i].resp, vecs[i].wr, vecs[i].rd);
      if (vecs[i].wr == 1) begin
        check($sformatf("vec%0d waddr", i), 32'(last_wa), 32'(vecs[i].b1[AW-1:0]));
        check($sformatf("vec%0d wdata", i), 32'(last_wd), 32'(vecs[i].b2));
      end
    end

    // Write latency: strobe in the cycle after the data byte, response 1 (or 3) later
    send_byte(W_OP); send_byte(8'h07); send_byte(8'h99);
    en = acc_cyc;
    get_resp(0, r);
    check("wr lat resp",   32'(r),               32'(K_RS));
    check("wr lat strobe", 32'(wr_cyc - en),     32'd0);
    check("wr lat tx",     32'(tx_cyc - en),     32'(1 + 2 * VF));

    // Read latency: strobe right after the addr byte, response two cycles after it
    send_byte(R_OP); send_byte(8'h07);
    en = acc_cyc;
    get_resp(0, r);
    check("rd lat resp",   32'(r),               32'h99);
    check("rd lat strobe", 32'(rd_cyc - en),     32'd0);
    check("rd lat addr",   32'(last_ra),         32'h07);
    check("rd lat tx",     32'(tx_cyc - en),     32'd2);

    // Timeout while waiting for the data byte: E after exactly TMO idle cycles + 1
    wr0 = wr_cnt;
    send_byte(W_OP); send_byte(8'h02);
    en = acc_cyc;
    get_resp(0, r);
    check("tmo data resp",   32'(r),            32'(E_RS));
    check("tmo data writes", 32'(wr_cnt - wr0), 32'd0);
    check("tmo data delay",  32'(tx_cyc - en),  32'(TMO + 1));
    do_frame("tmo follow rd", R_OP, 8'h02, 8'h00, 2, 0, 0, 8'h00, 0, 1);

    // Timeout while waiting for the addr byte
    rd0 = rd_cnt;
    send_byte(R_OP);
    en = acc_cyc;
    get_resp(0, r);
    check("tmo addr resp",  32'(r),            32'(E_RS));
    check("tmo addr reads", 32'(rd_cnt - rd0), 32'd0);
    check("tmo addr delay", 32'(tx_cyc - en),  32'(TMO + 1));

    // A byte arriving after exactly TMO idle cycles still wins
    do_frame("tmo edge wr", W_OP, 8'h03, 8'h6E, 3, TMO, 0, K_RS, 1, VF);
    do_frame("tmo edge rd", R_OP, 8'h03, 8'h00, 2, 0, 0, 8'h6E, 0, 1);

    // Back-pressure: response held 20 cycles while a new byte waits unconsumed
    send_byte(R_OP); send_byte(8'h10);
    en = 0;
    while (!bus.tx_valid && en < 50) begin @(posedge clk); #1; en++; end
    cap = bus.tx_data;
    check("hold resp", 32'(cap), 32'h3C);
    bus.rx_valid = 1'b1;
    bus.rx_data  = R_OP;
    bad = 1'b0;
    repeat (20) begin
      @(posedge clk); #1;
      if (!bus.tx_valid || bus.tx_data !== cap || bus.rx_ready) bad = 1'b1;
    end
    check("hold stable", 32'(bad), 32'd0);
    bus.tx_ready = 1'b1;
    @(posedge clk); #1;
    bus.tx_ready = 1'b0;
    @(posedge clk); #1;   // the waiting 'R' transfers now, in IDLE
    bus.rx_valid = 1'b0;
    send_byte(8'h10);
    get_resp(3, r);
    check("hold next rd", 32'(r), 32'h3C);

    // Write to the read-only register
    do_frame("ro write", W_OP, 8'(RO_ADDR), 8'h77, 3, 1, 0, (VF == 1) ? E_RS : K_RS, 1, VF);
    do_frame("ro read",  R_OP, 8'(RO_ADDR), 8'h00, 2, 0, 0, 8'h99, 0, 1);

    // Reset during BUS_RD
    rd0 = rd_cnt;
    send_byte(R_OP); send_byte(8'h10);
    rst = 1'b1;
    #1;
    check("midrst read_en",  32'(bus.reg_read_en),  32'd0);
    check("midrst write_en", 32'(bus.reg_write_en), 32'd0);
    check("midrst tx_valid", 32'(bus.tx_valid),     32'd0);
    check("midrst rx_ready", 32'(bus.rx_ready),     32'd0);
    check("midrst busy",     32'(busy),             32'd0);
    check("midrst reg_addr", 32'(bus.reg_addr),     32'd0);
    check("midrst tx_data",  32'(bus.tx_data),      32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    bad = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
      if (bus.tx_valid || busy) bad = 1'b1;
    end
    check("midrst no tx", 32'(bad),          32'd0);
    check("midrst reads", 32'(rd_cnt - rd0), 32'd0);

    // Randomized frames against the reference model (slave was reloaded by reset)
    ref_reset();
    for (int i = 0; i < 60; i++) begin
      kind = int'($urandom_range(0, 9));
      d    = 8'($urandom_range(0, 255));
      case (kind)
        0: begin
          op = 8'($urandom_range(0, 255));
          if (op == W_OP || op == R_OP) op = 8'h00;
          a = 8'h00;
        end
        1: begin
          op = ($urandom_range(0, 1) == 1) ? W_OP : R_OP;
          a  = 8'($urandom_range(DEPTH, 255));
        end
        2, 3, 4, 5: begin op = W_OP; a = 8'($urandom_range(0, DEPTH - 1)); end
        6:          begin op = W_OP; a = 8'(RO_ADDR); end
        default:    begin op = R_OP; a = 8'($urandom_range(0, DEPTH - 1)); end
      endcase
      model_frame(op, a, d, en, er, ewr, erd);
      do_frame($sformatf("rnd%0d", i), op, a, d, en, int'($urandom_range(0, 3)),
               int'($urandom_range(0, 2)), er, ewr, erd);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
